alu_share_ctrl: RTL and testbench
=================================

// Module: alu_share_ctrl
// PURPOSE
//  Shares one registered-output 32-bit ALU between two requesters (e.g. EX-stage sequencer, branch/address unit).
//  Round-robin arbitrates valid/ready requests, holds ALU operands stable for the issue cycle and captures the zero flag.
//  Collects the result one clock later and returns it to the granted requester as a single-cycle response pulse.
//  Sits between the requesters and the ALU; one operation in flight at a time.
// PARAMETERS
//  WIDTH    32  operand/result width
//  OP_W     4   ALU control code width
//  RR_INIT  0   requester treated as last-granted after reset (so the other wins the first tie)
// PORTS
//  clk          in   1      system clock, all state on posedge
//  rst_n        in   1      asynchronous active-low reset
//  reqN_valid   in   1      N=0,1: request present
//  reqN_ready   out  1      N=0,1: request accepted this cycle when valid&ready
//  reqN_op      in   OP_W   N=0,1: ALU control code
//  reqN_a/b     in   WIDTH  N=0,1: operands in1/in2
//  rspN_valid   out  1      N=0,1: one-cycle response pulse, no backpressure
//  rspN_data    out  WIDTH  N=0,1: result, held until next response to N
//  rspN_zero    out  1      N=0,1: in1==in2 flag for that op
//  rspN_err     out  1      N=0,1: op code not in legal set
//  alu_control  out  OP_W   to ALU control
//  alu_in1/in2  out  WIDTH  to ALU operands
//  alu_out      in   WIDTH  ALU registered result
//  alu_zero     in   1      ALU combinational equality flag
//  busy         out  1      high in ISSUE/CAPTURE
// BEHAVIOUR
//  Reset: state=IDLE; all ready/valid/err/zero/busy=0; data, alu_control, alu_in1/in2=0; last_grant=RR_INIT.
//  FSM IDLE -> ISSUE -> CAPTURE -> IDLE; one accept per 3 cycles max.
//  IDLE: ready asserted combinationally to exactly one requester: sole valid one; both valid -> the one != last_grant.
//   Neither valid: both ready=0. On valid&ready: latch op/a/b into ALU-driving regs, record grant, update last_grant, -> ISSUE.
//  ISSUE: alu_control/in1/in2 driven from latched regs (stable whole cycle); sample alu_zero and legality; -> CAPTURE.
//  CAPTURE: alu_out holds result of ISSUE operands; register into rsp<grant>_data, zero, err; -> IDLE.
//  rsp<grant>_valid high exactly the cycle after CAPTURE (first IDLE cycle); a new accept may occur in that same cycle.
//  Latency: accept edge t -> rsp_valid high in cycle t+3. The other requester's rsp outputs are unchanged.
//  ALU inputs keep last latched values outside ISSUE (no toggling); ready=0 in ISSUE/CAPTURE regardless of valid.
//  Legal ops: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 MIN(unsigned), 12 NOR. Illegal op still issued (ALU yields 0): data=0, err=1.
//  Arithmetic is the ALU's, modulo 2^WIDTH; the controller does no arithmetic or width change.
//  Requester dropping valid before ready: no accept, no state change. Request fields sampled only at accept edge.
//  rst_n asserted mid-op: immediate return to reset values; in-flight op discarded, no response ever issued for it.
// STRUCTURE
//  Shared package alu_pkg: localparams for the 6 op codes, is_legal_op function, FSM state encoding (2 bits).
//  One sub-module: rr_arb2 (2-way round-robin: valid[1:0], last_grant, advance -> grant[1:0] one-hot, registered last).
//  Top holds FSM, operand/grant regs and response regs; total ~150-250 lines.
// TESTING
//  req0 ADD a=5 b=7 alone -> req0_ready same cycle, rsp0_valid 3 cycles later, data=12, zero=0, err=0; rsp1 quiet.
//  req0 and req1 both valid every cycle after reset (RR_INIT=0) -> grants 1,0,1,0; responses alternate, every 3 cycles.
//  req1 SUB a=b=0x0000_00FF -> rsp1_data=0, rsp1_zero=1; MIN 0xFFFF_FFFF,3 -> 3; NOR 0,0 -> 0xFFFF_FFFF.
//  req0 op=4'hF a=1 b=1 -> rsp0_err=1, data=0, zero=1; next legal op clears err.
//  Assert rst_n low during CAPTURE -> no rsp pulse, outputs at reset values, next accept works normally.
//  req0 valid pulsed during ISSUE then dropped -> never accepted, no response; ALU inputs constant through ISSUE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: op codes, legality check, FSM states.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_MIN = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MIN, OP_NOR: is_legal_op = 1'b1;
      default:                                      is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from valids, last winner registered on advance.
module rr_arb2 #(
  parameter int unsigned RR_INIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_grant <= (RR_INIT != 0);
    else if (advance)
      last_grant <= grant[1];
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one registered-output ALU between two requesters; one op in flight, response 3 cycles after accept.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned RR_INIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_zero,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_zero,
  output logic             rsp1_err,
  output logic [OP_W-1:0]  alu_control,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             busy
);

  state_t     state, state_nxt;
  logic [1:0] grant;
  logic       accept;
  logic       gnt_r;
  logic       zero_r;
  logic       err_r;

  assign accept = (state == ST_IDLE) && (grant != 2'b00);

  rr_arb2 #(
    .RR_INIT (RR_INIT)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   ({req1_valid, req0_valid}),
    .advance (accept),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE:   state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // ready is gated by rst_n so a held-valid requester sees no handshake while in reset
  always_comb begin
    busy       = (state != ST_IDLE);
    req0_ready = rst_n && (state == ST_IDLE) && grant[0];
    req1_ready = rst_n && (state == ST_IDLE) && grant[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_control <= '0;
      alu_in1     <= '0;
      alu_in2     <= '0;
      gnt_r       <= 1'b0;
      zero_r      <= 1'b0;
      err_r       <= 1'b0;
      rsp0_valid  <= 1'b0;
      rsp0_data   <= '0;
      rsp0_zero   <= 1'b0;
      rsp0_err    <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_data   <= '0;
      rsp1_zero   <= 1'b0;
      rsp1_err    <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            gnt_r       <= grant[1];
            alu_control <= grant[1] ? req1_op : req0_op;
            alu_in1     <= grant[1] ? req1_a  : req0_a;
            alu_in2     <= grant[1] ? req1_b  : req0_b;
          end
        end
        ST_ISSUE: begin
          zero_r <= alu_zero;
          err_r  <= !is_legal_op(alu_control);
        end
        ST_CAPTURE: begin
          if (gnt_r) begin
            rsp1_valid <= 1'b1;
            rsp1_data  <= alu_out;
            rsp1_zero  <= zero_r;
            rsp1_err   <= err_r;
          end else begin
            rsp0_valid <= 1'b1;
            rsp0_data  <= alu_out;
            rsp0_zero  <= zero_r;
            rsp0_err   <= err_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: ALU model, transaction-level reference, directed then random stimulus.
module tb_alu_share_ctrl;

  localparam int unsigned W       = 32;
  localparam int unsigned OPW     = 4;
  localparam int unsigned RR_INIT = 0;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req0_valid = 1'b0, req1_valid = 1'b0;
  logic           req0_ready, req1_ready;
  logic [OPW-1:0] req0_op = '0, req1_op = '0;
  logic [W-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic           rsp0_valid, rsp0_zero, rsp0_err;
  logic           rsp1_valid, rsp1_zero, rsp1_err;
  logic [W-1:0]   rsp0_data, rsp1_data;
  logic [OPW-1:0] alu_control;
  logic [W-1:0]   alu_in1, alu_in2;
  logic [W-1:0]   alu_out = '0;
  logic           alu_zero;
  logic           busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(
    .WIDTH   (W),
    .OP_W    (OPW),
    .RR_INIT (RR_INIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op     (req0_op),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op     (req1_op),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp0_valid  (rsp0_valid),
    .rsp0_data   (rsp0_data),
    .rsp0_zero   (rsp0_zero),
    .rsp0_err    (rsp0_err),
    .rsp1_valid  (rsp1_valid),
    .rsp1_data   (rsp1_data),
    .rsp1_zero   (rsp1_zero),
    .rsp1_err    (rsp1_err),
    .alu_control (alu_control),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_out     (alu_out),
    .alu_zero    (alu_zero),
    .busy        (busy)
  );

  // ALU semantics: registered result, combinational equality flag, illegal op yields 0
  function automatic logic [W-1:0] alu_f(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'd0:    alu_f = a & b;
      4'd1:    alu_f = a | b;
      4'd2:    alu_f = a + b;
      4'd6:    alu_f = a - b;
      4'd7:    alu_f = (a < b) ? a : b;
      4'd12:   alu_f = ~(a | b);
      default: alu_f = '0;
    endcase
  endfunction

  function automatic logic legal(input logic [OPW-1:0] op);
    return (op == 4'd0) || (op == 4'd1) || (op == 4'd2) || (op == 4'd6) || (op == 4'd7) || (op == 4'd12);
  endfunction

  always @(posedge clk) alu_out <= alu_f(alu_control, alu_in1, alu_in2);
  assign alu_zero = (alu_in1 == alu_in2);

  // Reference: a request accepted in cycle c answers in cycle c+3; the controller refuses new work for 2 cycles
  typedef struct {
    int         due;
    bit         who;
    logic [W-1:0] d;
    logic       z;
    logic       e;
  } rsp_t;

  rsp_t           pq[$];
  int             cycle = 0;
  int             blocked = 0;
  int             m_last = RR_INIT;
  logic [W-1:0]   e_d[2];
  logic           e_z[2];
  logic           e_e[2];
  logic [OPW-1:0] m_op = '0;
  logic [W-1:0]   m_a = '0, m_b = '0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic model_reset();
    pq.delete();
    blocked = 0;
    m_last  = RR_INIT;
    m_op    = '0;
    m_a     = '0;
    m_b     = '0;
    for (int i = 0; i < 2; i++) begin
      e_d[i] = '0;
      e_z[i] = 1'b0;
      e_e[i] = 1'b0;
    end
  endtask

  task automatic check_outputs(input logic ev0, input logic ev1, input logic er0, input logic er1, input logic ebusy);
    chk("req0_ready", W'(req0_ready), W'(er0));
    chk("req1_ready", W'(req1_ready), W'(er1));
    chk("busy",       W'(busy),       W'(ebusy));
    chk("rsp0_valid", W'(rsp0_valid), W'(ev0));
    chk("rsp1_valid", W'(rsp1_valid), W'(ev1));
    chk("rsp0_data",  rsp0_data,      e_d[0]);
    chk("rsp0_zero",  W'(rsp0_zero),  W'(e_z[0]));
    chk("rsp0_err",   W'(rsp0_err),   W'(e_e[0]));
    chk("rsp1_data",  rsp1_data,      e_d[1]);
    chk("rsp1_zero",  W'(rsp1_zero),  W'(e_z[1]));
    chk("rsp1_err",   W'(rsp1_err),   W'(e_e[1]));
    chk("alu_control", W'(alu_control), W'(m_op));
    chk("alu_in1",    alu_in1,        m_a);
    chk("alu_in2",    alu_in2,        m_b);
  endtask

  // One clock cycle: drive at negedge, check after settling, advance the model, move to next negedge
  task automatic step(input logic v0, input logic [OPW-1:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input logic v1, input logic [OPW-1:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1);
    logic er0, er1, ev0, ev1;
    rsp_t r;
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    #1;
    er0 = 1'b0; er1 = 1'b0; ev0 = 1'b0; ev1 = 1'b0;
    if (blocked == 0) begin
      if (v0 && !v1)      er0 = 1'b1;
      else if (v1 && !v0) er1 = 1'b1;
      else if (v0 && v1) begin
        if (m_last == 0) er1 = 1'b1;
        else             er0 = 1'b1;
      end
    end
    if (pq.size() > 0 && pq[0].due == cycle) begin
      r = pq.pop_front();
      if (r.who) ev1 = 1'b1; else ev0 = 1'b1;
      e_d[r.who] = r.d;
      e_z[r.who] = r.z;
      e_e[r.who] = r.e;
    end
    check_outputs(ev0, ev1, er0, er1, blocked != 0);
    if (er0 || er1) begin
      r.who  = er1;
      r.due  = cycle + 3;
      m_op   = er1 ? op1 : op0;
      m_a    = er1 ? a1  : a0;
      m_b    = er1 ? b1  : b0;
      r.d    = alu_f(m_op, m_a, m_b);
      r.z    = (m_a == m_b);
      r.e    = !legal(m_op);
      pq.push_back(r);
      m_last  = er1 ? 1 : 0;
      blocked = 2;
    end else if (blocked > 0) begin
      blocked--;
    end
    @(posedge clk);
    cycle++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  // Called at a negedge; reset is asserted with a valid held high to show ready stays low
  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    model_reset();
    check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  logic [OPW-1:0] op_tab[8];

  initial begin
    op_tab[0] = 4'd0;  op_tab[1] = 4'd1; op_tab[2] = 4'd2;  op_tab[3] = 4'd6;
    op_tab[4] = 4'd7;  op_tab[5] = 4'd12; op_tab[6] = 4'd3; op_tab[7] = 4'd15;

    @(negedge clk);
    do_reset();

    // lone ADD from requester 0
    step(1'b1, 4'd2, 32'd5, 32'd7, 1'b0, '0, '0, '0);
    idle(4);
    chk("add_5_7", rsp0_data, 32'd12);

    // both requesters always valid from reset: grants 1,0,1,0
    do_reset();
    for (int i = 0; i < 12; i++)
      step(1'b1, 4'd0, 32'hF0F0_F0F0, W'(i), 1'b1, 4'd1, W'(i), 32'h0000_0100);
    idle(4);

    // boundary arithmetic on requester 1
    step(1'b0, '0, '0, '0, 1'b1, 4'd6, 32'h0000_00FF, 32'h0000_00FF);
    idle(3);
    chk("sub_eq_data", rsp1_data, 32'd0);
    chk("sub_eq_zero", W'(rsp1_zero), 32'd1);
    step(1'b0, '0, '0, '0, 1'b1, 4'd7, 32'hFFFF_FFFF, 32'd3);
    idle(3);
    chk("min_u", rsp1_data, 32'd3);
    step(1'b0, '0, '0, '0, 1'b1, 4'd12, 32'd0, 32'd0);
    idle(3);
    chk("nor_0", rsp1_data, 32'hFFFF_FFFF);

    // illegal op then a legal one
    step(1'b1, 4'hF, 32'd1, 32'd1, 1'b0, '0, '0, '0);
    idle(3);
    chk("ill_err", W'(rsp0_err), 32'd1);
    chk("ill_data", rsp0_data, 32'd0);
    step(1'b1, 4'd1, 32'd4, 32'd2, 1'b0, '0, '0, '0);
    idle(3);
    chk("legal_clears_err", W'(rsp0_err), 32'd0);

    // reset during CAPTURE discards the op; the next accept behaves normally
    step(1'b0, '0, '0, '0, 1'b1, 4'd2, 32'd100, 32'd23);
    idle(1);
    do_reset();
    idle(3);
    step(1'b0, '0, '0, '0, 1'b1, 4'd2, 32'd9, 32'd1);
    idle(4);
    chk("after_rst_add", rsp1_data, 32'd10);

    // valid pulsed during ISSUE and dropped is never accepted
    step(1'b1, 4'd2, 32'd1, 32'd2, 1'b0, '0, '0, '0);
    step(1'b1, 4'd6, 32'hDEAD, 32'hBEEF, 1'b0, '0, '0, '0);
    idle(5);
    chk("pulse_ignored", rsp0_data, 32'd3);

    // random traffic, fields change freely while not accepted
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] a0, b0, a1, b1;
      a0 = $urandom; a1 = $urandom;
      b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
      step($urandom_range(0, 2) != 0, op_tab[$urandom_range(0, 7)], a0, b0,
           $urandom_range(0, 2) != 0, op_tab[$urandom_range(0, 7)], a1, b1);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
